// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB matrix arbiters: parameter defaults and
// one-hot/index conversion helpers sized for the widest supported matrix.
package ahb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 32;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned DEF_MASTERS = 8;
  localparam int unsigned DEF_AGE_BIT = 8;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/ahb_arb_qos_rr.sv
// Masked round-robin picker: lowest requester at or above ptr, else lowest
// requester overall. Purely combinational.
module ahb_arb_qos_rr #(
  parameter int unsigned MASTERS     = 8,
  parameter int unsigned MASTERS_BIT = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]     req,
  input  logic [MASTERS_BIT-1:0] ptr,
  output logic [MASTERS-1:0]     grant
);

  logic [MASTERS-1:0] masked;
  logic [MASTERS-1:0] pick;

  always_comb begin
    masked = req & ({MASTERS{1'b1}} << ptr);
    pick   = (|masked) ? masked : req;
    // Isolate lowest set bit.
    grant  = pick & (~pick + MASTERS'(1));
  end

endmodule

// File: rtl/ahb_arb_qos.sv
// Per-slave-port AHB arbiter: priority levels with round robin per level,
// aging-based urgent tier, HMASTLOCK ownership hold and registered owner.
module ahb_arb_qos
  import ahb_arb_pkg::*;
#(
  parameter int unsigned MASTERS     = DEF_MASTERS,
  parameter int unsigned LEVELS      = MASTERS,
  parameter int unsigned MASTERS_BIT = $clog2(MASTERS),
  parameter int unsigned LEVEL_BIT   = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  parameter int unsigned AGE_BIT     = DEF_AGE_BIT
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [MASTERS*LEVEL_BIT-1:0]   ARB_PRIORITY,
  input  logic [AGE_BIT-1:0]             ARB_AGE_LIMIT,
  input  logic [MASTERS-1:0]             ARB_REQ,
  output logic [MASTERS-1:0]             ARB_REQ_ACK,
  output logic [MASTERS-1:0]             ARB_GRANT,
  input  logic [MASTERS-1:0]             ARB_GRANT_ACK,
  input  logic                           ARB_LOCK,
  output logic [MASTERS_BIT-1:0]         ARB_OWNER,
  output logic                           ARB_OWNER_VLD,
  output logic [MASTERS-1:0]             ARB_URGENT
);

  localparam int unsigned TIERS    = LEVELS + 1;
  localparam int unsigned TIER_BIT = $clog2(TIERS);

  logic [LEVEL_BIT-1:0]                lvl [MASTERS];
  logic [MASTERS-1:0]                  urgent;
  logic [TIERS-1:0][MASTERS-1:0]       tier_req;
  logic [TIERS-1:0][MASTERS-1:0]       tier_gnt;
  logic [MASTERS-1:0]                  arb_gnt;
  logic [TIER_BIT-1:0]                 sel_tier;
  logic [MASTERS-1:0]                  grant;
  logic [MASTERS-1:0]                  accept;
  logic                                acc_any;
  logic                                lock_act;
  logic [MASTERS_BIT-1:0]              acc_idx;
  logic [MASTERS_BIT-1:0]              ptr_next;

  logic [TIERS-1:0][MASTERS_BIT-1:0]   ptr_q, ptr_d;
  logic [AGE_BIT-1:0]                  age_q [MASTERS];
  logic [AGE_BIT-1:0]                  age_d [MASTERS];
  logic [MASTERS_BIT-1:0]              owner_q, owner_d;
  logic                                owner_vld_q, owner_vld_d;

  // Effective level per master (out-of-range folds to lowest level) and aging promotion.
  always_comb begin
    for (int unsigned m = 0; m < MASTERS; m++) begin
      lvl[m] = (ARB_PRIORITY[m*LEVEL_BIT +: LEVEL_BIT] > LEVEL_BIT'(LEVELS-1))
             ? LEVEL_BIT'(LEVELS-1) : ARB_PRIORITY[m*LEVEL_BIT +: LEVEL_BIT];
      urgent[m] = (ARB_AGE_LIMIT != '0) && ARB_REQ[m] && (age_q[m] >= ARB_AGE_LIMIT);
    end
  end

  // Tier request vectors; an urgent master appears only in the urgent tier.
  always_comb begin
    tier_req = '0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      for (int unsigned m = 0; m < MASTERS; m++) begin
        tier_req[l][m] = ARB_REQ[m] && !urgent[m] && (lvl[m] == LEVEL_BIT'(l));
      end
    end
    tier_req[LEVELS] = urgent;
  end

  for (genvar t = 0; t < TIERS; t++) begin : g_tier
    ahb_arb_qos_rr #(
      .MASTERS     (MASTERS),
      .MASTERS_BIT (MASTERS_BIT)
    ) u_rr (
      .req   (tier_req[t]),
      .ptr   (ptr_q[t]),
      .grant (tier_gnt[t])
    );
  end

  // First non-empty tier wins: urgent, then level 0 downwards.
  always_comb begin
    arb_gnt  = '0;
    sel_tier = '0;
    for (int l = int'(LEVELS) - 1; l >= 0; l--) begin
      if (|tier_req[l]) begin
        arb_gnt  = tier_gnt[l];
        sel_tier = TIER_BIT'(l);
      end
    end
    if (|urgent) begin
      arb_gnt  = tier_gnt[LEVELS];
      sel_tier = TIER_BIT'(LEVELS);
    end
  end

  always_comb begin
    lock_act = ARB_LOCK && owner_vld_q;
    grant    = lock_act ? MASTERS'(idx_to_onehot(IDX_W'(owner_q))) : arb_gnt;
    accept   = grant & ARB_GRANT_ACK;
    acc_any  = |accept;
    acc_idx  = MASTERS_BIT'(onehot_to_idx(MAX_MASTERS'(accept)));
    ptr_next = (acc_idx == MASTERS_BIT'(MASTERS-1)) ? '0 : acc_idx + MASTERS_BIT'(1);
  end

  // Next state: pointers freeze under lock, aging always runs.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned t = 0; t < TIERS; t++) begin
      if (acc_any && !lock_act && (sel_tier == TIER_BIT'(t))) ptr_d[t] = ptr_next;
    end
    for (int unsigned m = 0; m < MASTERS; m++) begin
      if (!ARB_REQ[m] || accept[m]) age_d[m] = '0;
      else if (age_q[m] == {AGE_BIT{1'b1}}) age_d[m] = age_q[m];
      else age_d[m] = age_q[m] + AGE_BIT'(1);
    end
    owner_d     = acc_any ? acc_idx : owner_q;
    owner_vld_d = owner_vld_q || acc_any;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      for (int unsigned m = 0; m < MASTERS; m++) age_q[m] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      for (int unsigned m = 0; m < MASTERS; m++) age_q[m] <= age_d[m];
    end
  end

  assign ARB_GRANT     = grant;
  assign ARB_REQ_ACK   = ARB_REQ & accept;
  assign ARB_OWNER     = owner_q;
  assign ARB_OWNER_VLD = owner_vld_q;
  assign ARB_URGENT    = urgent;

endmodule

// File: tb/tb_ahb_arb_qos.sv
// Directed scoreboard bench for ahb_arb_qos: an 8-master instance and a
// 3-master single-level instance sharing clock and reset.
module tb_ahb_arb_qos;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-master instance
  logic [2:0]  prio8 [8];
  logic [23:0] pri8;
  logic [7:0]  lim8, req8, ack8, g8, ra8, urg8;
  logic        lock8, vld8;
  logic [2:0]  own8;

  // 3-master, single-level instance
  logic [2:0]  pri3;
  logic [7:0]  lim3;
  logic [2:0]  req3, ack3, g3, ra3, urg3;
  logic        lock3, vld3;
  logic [1:0]  own3;

  always_comb begin
    pri8 = '0;
    for (int m = 0; m < 8; m++) pri8[m*3 +: 3] = prio8[m];
  end

  ahb_arb_qos #(.MASTERS(8)) u_dut8 (
    .HCLK(clk), .HRESETn(rst_n), .ARB_PRIORITY(pri8), .ARB_AGE_LIMIT(lim8),
    .ARB_REQ(req8), .ARB_REQ_ACK(ra8), .ARB_GRANT(g8), .ARB_GRANT_ACK(ack8),
    .ARB_LOCK(lock8), .ARB_OWNER(own8), .ARB_OWNER_VLD(vld8), .ARB_URGENT(urg8)
  );

  ahb_arb_qos #(.MASTERS(3), .LEVELS(1)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .ARB_PRIORITY(pri3), .ARB_AGE_LIMIT(lim3),
    .ARB_REQ(req3), .ARB_REQ_ACK(ra3), .ARB_GRANT(g3), .ARB_GRANT_ACK(ack3),
    .ARB_LOCK(lock3), .ARB_OWNER(own3), .ARB_OWNER_VLD(vld3), .ARB_URGENT(urg3)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req8 = '0; ack8 = '0; lock8 = 1'b0; lim8 = '0;
    req3 = '0; ack3 = '0; lock3 = 1'b0; lim3 = '0;
    for (int m = 0; m < 8; m++) prio8[m] = 3'd7;
    pri3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Drive a request pattern with ack following the expected grant.
  task automatic step8(input logic [7:0] req, input logic [7:0] exp_g, input string tag);
    req8 = req;
    ack8 = exp_g;
    sb_push({tag, "_grant"}, 32'(exp_g));
    sb_push({tag, "_reqack"}, 32'(req & exp_g));
    #2;
    sb_check(32'(g8));
    sb_check(32'(ra8));
    tick();
  endtask

  task automatic step3(input logic [2:0] req, input logic [2:0] exp_g, input string tag);
    req3 = req;
    ack3 = exp_g;
    sb_push({tag, "_grant"}, 32'(exp_g));
    sb_push({tag, "_reqack"}, 32'(req & exp_g));
    #2;
    sb_check(32'(g3));
    sb_check(32'(ra3));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req8 = '0; ack8 = '0; lock8 = 1'b0; lim8 = '0;
    req3 = '0; ack3 = '0; lock3 = 1'b0; lim3 = '0;
    for (int m = 0; m < 8; m++) prio8[m] = 3'd7;
    pri3 = '0;
    #2;
    // Reset state
    sb_push("rst_grant", 32'h0);   sb_check(32'(g8));
    sb_push("rst_vld", 32'h0);     sb_check(32'(vld8));
    sb_push("rst_owner", 32'h0);   sb_check(32'(own8));
    sb_push("rst_urgent", 32'h0);  sb_check(32'(urg8));
    sb_push("rst_urgent3", 32'h0); sb_check(32'(urg3));
    do_reset();

    // 1: equal priority rotation M0..M3 and wrap
    for (int m = 0; m < 8; m++) prio8[m] = 3'd0;
    step8(8'h0F, 8'h01, "t1_m0");
    sb_push("t1_owner0", 32'h0); sb_check(32'(own8));
    sb_push("t1_vld", 32'h1);    sb_check(32'(vld8));
    step8(8'h0F, 8'h02, "t1_m1");
    step8(8'h0F, 8'h04, "t1_m2");
    step8(8'h0F, 8'h08, "t1_m3");
    sb_push("t1_owner3", 32'h3); sb_check(32'(own8));
    step8(8'h0F, 8'h01, "t1_wrap_m0");

    // 2: level 0 beats level 2; lower level takes over when higher drops
    do_reset();
    prio8[5] = 3'd0;
    prio8[1] = 3'd2;
    req8 = 8'h22; ack8 = 8'h00;
    sb_push("t2_m5", 32'h20); #2; sb_check(32'(g8));
    tick();
    req8 = 8'h02;
    sb_push("t2_m1", 32'h02); #2; sb_check(32'(g8));
    tick();

    // 3: aging promotes level-7 master after 4 waits
    do_reset();
    lim8 = 8'd4;
    prio8[0] = 3'd0;
    prio8[7] = 3'd7;
    for (int i = 0; i < 4; i++) step8(8'h81, 8'h01, "t3_wait");
    sb_push("t3_urgent_on", 32'h80); sb_check(32'(urg8));
    step8(8'h81, 8'h80, "t3_promo");
    sb_push("t3_urgent_off", 32'h00); sb_check(32'(urg8));
    sb_push("t3_owner7", 32'h7);      sb_check(32'(own8));
    step8(8'h81, 8'h01, "t3_resume");

    // 4: lock holds owner even after it drops request
    do_reset();
    prio8[2] = 3'd1;
    prio8[0] = 3'd0;
    step8(8'h04, 8'h04, "t4_acc");
    sb_push("t4_owner2", 32'h2); sb_check(32'(own8));
    lock8 = 1'b1; req8 = 8'h01; ack8 = 8'h00;
    sb_push("t4_hold0", 32'h04); #2; sb_check(32'(g8));
    tick();
    sb_push("t4_hold1", 32'h04); sb_check(32'(g8));
    ack8 = 8'h04;
    sb_push("t4_reqack_noreq", 32'h00); #1; sb_check(32'(ra8));
    tick();
    lock8 = 1'b0; ack8 = 8'h00;
    sb_push("t4_release", 32'h01); #2; sb_check(32'(g8));
    tick();

    // 5: asynchronous reset mid-rotation
    do_reset();
    for (int m = 0; m < 8; m++) prio8[m] = 3'd0;
    step8(8'h0F, 8'h01, "t5_m0");
    step8(8'h0F, 8'h02, "t5_m1");
    step8(8'h0F, 8'h04, "t5_m2");
    req8 = 8'h0F; ack8 = 8'h00;
    sb_push("t5_pre_m3", 32'h08); #2; sb_check(32'(g8));
    rst_n = 1'b0;
    #1;
    sb_push("t5_rst_vld", 32'h0);    sb_check(32'(vld8));
    sb_push("t5_rst_owner", 32'h0);  sb_check(32'(own8));
    sb_push("t5_rst_grant", 32'h01); sb_check(32'(g8));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    step8(8'h0F, 8'h01, "t5_post");

    // 6: 3 masters, one level; out-of-range priority folds into level 0
    do_reset();
    pri3 = 3'b010;
    step3(3'b111, 3'b001, "t6_m0");
    step3(3'b111, 3'b010, "t6_m1");
    step3(3'b111, 3'b100, "t6_m2");
    sb_push("t6_owner2", 32'h2); sb_check(32'(own3));
    sb_push("t6_vld", 32'h1);    sb_check(32'(vld3));
    step3(3'b111, 3'b001, "t6_wrap_m0");
    step3(3'b110, 3'b010, "t6_m1_again");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
